// File: rtl/ucode_sequencer.sv
// Microcode sequencer feeding the instruction decoder: holds IR, phase, fetch/exception flags
// and runs the FETCH -> EXEC -> (EXC) cycle with memory stalls, halt, wait and interrupt entry.
module ucode_sequencer #(
  parameter int          UC_END_BIT     = 0,
  parameter int          UC_IR_LOAD_BIT = 1,
  parameter int          UC_MEM_BIT     = 2,
  parameter logic [15:0] INT_OPCODE     = 16'h8000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [27:0] ucode_word,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  input  logic        irq,
  input  logic [8:0]  irq_vec,
  input  logic        halt,
  input  logic        wait_i,
  input  logic        ei,
  input  logic        di,
  output logic [15:0] instruction,
  output logic [2:0]  phase,
  output logic        fetch,
  output logic        exc_triggered,
  output logic [27:0] ucommand,
  output logic        commit,
  output logic        ie,
  output logic        halted,
  output logic        ucode_err
);

  // state   | meaning
  // FETCH   | running the fetch microprogram
  // EXEC    | running the microprogram of the instruction in IR
  // EXC     | running the injected INT microprogram
  // WAITING | idle until irq, no microcommands issued
  // HALTED  | stopped by HALT or microcode overflow; only reset leaves
  typedef enum logic [2:0] {ST_FETCH, ST_EXEC, ST_EXC, ST_WAITING, ST_HALTED} state_t;

  state_t      state, state_nxt;
  logic [2:0]  phase_nxt;
  logic [15:0] instr_nxt;
  logic        ie_nxt, halted_nxt, err_nxt;
  logic        running;
  logic        uc_end, uc_load, uc_mem;
  logic [15:0] int_image;

  assign uc_end    = ucode_word[UC_END_BIT];
  assign uc_load   = ucode_word[UC_IR_LOAD_BIT];
  assign uc_mem    = ucode_word[UC_MEM_BIT];
  assign int_image = INT_OPCODE | {7'd0, irq_vec};

  assign running       = (state == ST_FETCH) || (state == ST_EXEC) || (state == ST_EXC);
  assign fetch         = (state == ST_FETCH);
  assign exc_triggered = (state == ST_EXC);
  // ucommand stays driven during a stall so the memory request persists
  assign ucommand      = running ? ucode_word : 28'd0;
  assign commit        = running && (!uc_mem || mem_ready);

  always_comb begin
    state_nxt  = state;
    phase_nxt  = phase;
    instr_nxt  = instruction;
    ie_nxt     = ie;
    halted_nxt = halted;
    err_nxt    = ucode_err;
    if (commit) begin
      if (uc_load && state == ST_FETCH) instr_nxt = mem_rdata;
      if (!uc_end) begin
        if (phase == 3'd7) begin
          err_nxt    = 1'b1;
          halted_nxt = 1'b1;
          state_nxt  = ST_HALTED;
          phase_nxt  = 3'd0;
        end else begin
          phase_nxt = phase + 3'd1;
        end
      end else begin
        phase_nxt = 3'd0;
        case (state)
          ST_FETCH: state_nxt = ST_EXEC;
          ST_EXEC: begin
            // irq is qualified by the old ie, so ei only takes effect after the next instruction
            if (halt) begin
              state_nxt  = ST_HALTED;
              halted_nxt = 1'b1;
            end else if (wait_i) begin
              state_nxt = ST_WAITING;
            end else if (ei) begin
              ie_nxt    = 1'b1;
              state_nxt = ST_FETCH;
            end else if (di) begin
              ie_nxt    = 1'b0;
              state_nxt = ST_FETCH;
            end else if (irq && ie) begin
              state_nxt = ST_EXC;
              instr_nxt = int_image;
              ie_nxt    = 1'b0;
            end else begin
              state_nxt = ST_FETCH;
            end
          end
          default: state_nxt = ST_FETCH;
        endcase
      end
    end else if (state == ST_WAITING && irq) begin
      state_nxt = ST_EXC;
      instr_nxt = int_image;
      ie_nxt    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_FETCH;
      phase       <= 3'd0;
      instruction <= 16'd0;
      ie          <= 1'b0;
      halted      <= 1'b0;
      ucode_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      phase       <= phase_nxt;
      instruction <= instr_nxt;
      ie          <= ie_nxt;
      halted      <= halted_nxt;
      ucode_err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_ucode_sequencer.sv
// Directed table-driven bench for ucode_sequencer plus hand-written stall, wait, halt,
// overflow and async-reset sequences.
module tb_ucode_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [27:0] ucode_word = '0;
  logic        mem_ready = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        irq = 1'b0;
  logic [8:0]  irq_vec = '0;
  logic        halt = 1'b0, wait_i = 1'b0, ei = 1'b0, di = 1'b0;
  logic [15:0] instruction;
  logic [2:0]  phase;
  logic        fetch, exc_triggered, commit, ie, halted, ucode_err;
  logic [27:0] ucommand;

  int errors = 0;
  int checks = 0;

  localparam logic [27:0] P      = 28'h5A5A5A8;
  localparam logic [27:0] U_STEP = P;
  localparam logic [27:0] U_END  = P | 28'd1;
  localparam logic [27:0] U_LOAD = P | 28'd2;
  localparam logic [27:0] U_ME   = P | 28'd5;
  localparam logic [27:0] U_LM   = P | 28'd6;
  localparam logic [27:0] U_LME  = P | 28'd7;

  ucode_sequencer dut (
    .clk(clk), .rst_n(rst_n), .ucode_word(ucode_word), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .irq(irq), .irq_vec(irq_vec), .halt(halt), .wait_i(wait_i),
    .ei(ei), .di(di), .instruction(instruction), .phase(phase), .fetch(fetch),
    .exc_triggered(exc_triggered), .ucommand(ucommand), .commit(commit), .ie(ie),
    .halted(halted), .ucode_err(ucode_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [27:0] uw;
    logic        rdy;
    logic [15:0] rdata;
    logic        irq;
    logic [8:0]  vec;
    logic        halt, wt, ei, di;
    logic        e_commit, e_cmd;
    logic [15:0] e_instr;
    logic [2:0]  e_phase;
    logic        e_fetch, e_exc, e_ie, e_halted, e_err;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called just after a falling edge: drive, check combinational outputs, clock, check registers.
  task automatic step(input vec_t v, input string tag);
    ucode_word = v.uw; mem_ready = v.rdy; mem_rdata = v.rdata; irq = v.irq;
    irq_vec = v.vec; halt = v.halt; wait_i = v.wt; ei = v.ei; di = v.di;
    #1;
    chk($sformatf("%s commit", tag), 32'(commit), 32'(v.e_commit));
    chk($sformatf("%s ucommand", tag), 32'(ucommand), v.e_cmd ? 32'(v.uw) : 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("%s instruction", tag), 32'(instruction), 32'(v.e_instr));
    chk($sformatf("%s phase", tag), 32'(phase), 32'(v.e_phase));
    chk($sformatf("%s fetch", tag), 32'(fetch), 32'(v.e_fetch));
    chk($sformatf("%s exc_triggered", tag), 32'(exc_triggered), 32'(v.e_exc));
    chk($sformatf("%s ie", tag), 32'(ie), 32'(v.e_ie));
    chk($sformatf("%s halted", tag), 32'(halted), 32'(v.e_halted));
    chk($sformatf("%s ucode_err", tag), 32'(ucode_err), 32'(v.e_err));
  endtask

  task automatic chk_reset(input string tag);
    chk($sformatf("%s rst instruction", tag), 32'(instruction), 32'd0);
    chk($sformatf("%s rst phase", tag), 32'(phase), 32'd0);
    chk($sformatf("%s rst fetch", tag), 32'(fetch), 32'd1);
    chk($sformatf("%s rst exc_triggered", tag), 32'(exc_triggered), 32'd0);
    chk($sformatf("%s rst ie", tag), 32'(ie), 32'd0);
    chk($sformatf("%s rst halted", tag), 32'(halted), 32'd0);
    chk($sformatf("%s rst ucode_err", tag), 32'(ucode_err), 32'd0);
  endtask

  task automatic do_reset();
    ucode_word = '0; mem_ready = 1'b0; mem_rdata = '0; irq = 1'b0; irq_vec = '0;
    halt = 1'b0; wait_i = 1'b0; ei = 1'b0; di = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t v;
    // uw rdy rdata irq vec halt wt ei di | commit cmd instr phase fetch exc ie halted err
    tbl[0]  = '{U_LME,  1'b1, 16'h2A41, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h2A41, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{U_STEP, 1'b0, 16'h0000, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h2A41, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{U_END,  1'b0, 16'h0000, 1'b1, 9'h005, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h2A41, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{U_LME,  1'b1, 16'h1234, 1'b1, 9'h005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{U_END,  1'b0, 16'h0000, 1'b1, 9'h005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h8005, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{U_LM,   1'b1, 16'hFFFF, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h8005, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{U_END,  1'b0, 16'h0000, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h8005, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{U_LME,  1'b1, 16'h0F0F, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0F0F, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{U_END,  1'b0, 16'h0000, 1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0F0F, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{U_LME,  1'b1, 16'h3C3C, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h3C3C, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{U_END,  1'b0, 16'h0000, 1'b1, 9'h0AA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h3C3C, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{U_LME,  1'b1, 16'h7001, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h7001, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{U_END,  1'b0, 16'h0000, 1'b1, 9'h005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h7001, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{U_LOAD, 1'b0, 16'h5555, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h5555, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{U_ME,   1'b0, 16'h0000, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5555, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{U_ME,   1'b1, 16'h0000, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h5555, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{U_END,  1'b0, 16'h0000, 1'b0, 9'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h5555, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    #2;
    chk_reset("por");
    do_reset();
    chk_reset("init");
    for (int i = 0; i < 17; i++) step(tbl[i], $sformatf("v%0d", i));

    // Halted core ignores everything for 20 cycles
    for (int i = 0; i < 20; i++) begin
      v = '{U_LME, 1'b1, 16'(i * 16'h1111), 1'b1, 9'(i), 1'b0, 1'b0, 1'b1, 1'b0,
            1'b0, 1'b0, 16'h5555, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      step(v, $sformatf("frozen%0d", i));
    end

    // Memory stall: three cycles without mem_ready, then commit
    do_reset();
    for (int i = 0; i < 3; i++) begin
      v = '{U_LM, 1'b0, 16'hDEAD, 1'b0, 9'h0, 1'b0, 1'b0, 1'b0, 1'b0,
            1'b0, 1'b1, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      step(v, $sformatf("stall%0d", i));
    end
    v = '{U_LM, 1'b1, 16'hDEAD, 1'b0, 9'h0, 1'b0, 1'b0, 1'b0, 1'b0,
          1'b1, 1'b1, 16'hDEAD, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    step(v, "stall_go");

    // Wait: no microcommands until irq, then vector entry even with ie=0
    do_reset();
    v = '{U_END, 1'b0, 16'h0, 1'b0, 9'h0, 1'b0, 1'b0, 1'b0, 1'b0,
          1'b1, 1'b1, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    step(v, "w_fetch");
    v = '{U_END, 1'b0, 16'h0, 1'b0, 9'h0, 1'b0, 1'b1, 1'b0, 1'b0,
          1'b1, 1'b1, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    step(v, "w_enter");
    for (int i = 0; i < 3; i++) begin
      v = '{U_LME, 1'b1, 16'h1111, 1'b0, 9'h1FF, 1'b0, 1'b0, 1'b0, 1'b0,
            1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      step(v, $sformatf("w_idle%0d", i));
    end
    v = '{U_LME, 1'b1, 16'h1111, 1'b1, 9'h1FF, 1'b0, 1'b0, 1'b0, 1'b0,
          1'b0, 1'b0, 16'h81FF, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    step(v, "w_wake");
    v = '{U_END, 1'b0, 16'h0, 1'b0, 9'h0, 1'b0, 1'b0, 1'b0, 1'b0,
          1'b1, 1'b1, 16'h81FF, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    step(v, "w_int_end");

    // Async reset in the middle of a microprogram
    do_reset();
    v = '{U_LME, 1'b1, 16'hBEEF, 1'b0, 9'h0, 1'b0, 1'b0, 1'b0, 1'b0,
          1'b1, 1'b1, 16'hBEEF, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    step(v, "r_fetch");
    for (int i = 1; i <= 3; i++) begin
      v = '{U_STEP, 1'b0, 16'h0, 1'b0, 9'h0, 1'b0, 1'b0, 1'b0, 1'b0,
            1'b1, 1'b1, 16'hBEEF, 3'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      step(v, $sformatf("r_step%0d", i));
    end
    ucode_word = U_LME; mem_ready = 1'b1; mem_rdata = 16'hCAFE;
    #2 rst_n = 1'b0;
    #1 chk_reset("mid");
    @(posedge clk);
    #1 chk_reset("mid_held");
    @(negedge clk);
    rst_n = 1'b1;

    // Overflow: eight steps without END
    do_reset();
    v = '{U_END, 1'b0, 16'h0, 1'b0, 9'h0, 1'b0, 1'b0, 1'b0, 1'b0,
          1'b1, 1'b1, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    step(v, "o_fetch");
    for (int i = 1; i <= 7; i++) begin
      v = '{U_STEP, 1'b0, 16'h0, 1'b0, 9'h0, 1'b0, 1'b0, 1'b0, 1'b0,
            1'b1, 1'b1, 16'h0000, 3'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      step(v, $sformatf("o_step%0d", i));
    end
    v = '{U_STEP, 1'b0, 16'h0, 1'b0, 9'h0, 1'b0, 1'b0, 1'b0, 1'b0,
          1'b1, 1'b1, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    step(v, "o_overflow");
    v = '{U_END, 1'b1, 16'h0, 1'b1, 9'h0, 1'b0, 1'b0, 1'b0, 1'b0,
          1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    step(v, "o_frozen");
    #2 rst_n = 1'b0;
    #1 chk_reset("o_clear");
    @(negedge clk);
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
